dmux8_rr_arbiter: RTL

- Round-robin arbiter that shares one DMux8Way routing path between 8 requesters.
- Picks one requester, drives the DMux8Way sel/in pair, and exposes the resulting one-hot grant.
- Typical use: sequencing load strobes into RAM8/register-bank slots when several sources contend for the single write path.
- Supports bounded bursts so a requester can keep the path for consecutive cycles without starving the others.

---
 rtl/dmux8_rr_arbiter_pkg.sv | 16 +
 rtl/dmux8_rr_arbiter_if.sv | 24 ++
 rtl/dmux8_rr_arbiter_rr_priority8.sv | 29 ++
 rtl/dmux8_rr_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/dmux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin DMux arbiter.
// Holds the FSM encoding, requester/select widths and the burst counter width.
// Imported by the interface, the priority scanner and the top.
package dmux8_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  // IDLE must encode as 0 so a cleared state register means "no owner".
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dmux8_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master = requester side (drives req/hold), slave = arbiter side.
// Purely wiring, no logic.
interface dmux8_rr_arbiter_if;
  import dmux8_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             hold;
  logic [SEL_W-1:0] sel;
  logic             grant_valid;
  logic [N_REQ-1:0] gnt;
  logic             busy;

  modport master (
    output req, hold,
    input  sel, grant_valid, gnt, busy
  );

  modport slave (
    input  req, hold,
    output sel, grant_valid, gnt, busy
  );

endinterface

// File: rtl/dmux8_rr_arbiter_rr_priority8.sv
// Rotating first-set-bit finder over 8 requests.
// Purely combinational: idx is the first set bit at or after start, wrapping 7->0.
// any=0 when no request is set; idx then reads back start.
module rr_priority8
  import dmux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] k;

  // Scan from the farthest offset back toward start so the nearest set bit wins.
  always_comb begin
    any = 1'b0;
    idx = start;
    k   = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start + SEL_W'(i);
      if (req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/dmux8_rr_arbiter.sv
// Round-robin arbiter sharing one DMux8Way path between 8 requesters.
// One-cycle latency from req to grant; all outputs come from registers.
// hold freezes every register; bursts are capped at BURST_MAX cycles when others wait.
module dmux8_rr_arbiter
  import dmux8_rr_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4   // 1..16; 1 rotates every cycle
) (
  input  logic                clk,
  input  logic                rst_n,
  dmux8_rr_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SEL_W-1:0] last_q,  last_d;

  logic [SEL_W-1:0] start;
  logic             any;
  logic [SEL_W-1:0] idx;

  // The current owner ranks lowest; after IDLE the last winner ranks lowest.
  assign start = (state_q == ST_GRANT) ? sel_q + SEL_W'(1) : last_q + SEL_W'(1);

  rr_priority8 u_prio (
    .req   (bus.req),
    .start (start),
    .any   (any),
    .idx   (idx)
  );

  // State and grant registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state: extend the burst while allowed, otherwise re-arbitrate over all requests.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (!bus.hold) begin
      unique case (state_q)
        ST_IDLE: begin
          if (any) begin
            state_d = ST_GRANT;
            sel_d   = idx;
            cnt_d   = '0;
            last_d  = idx;
          end
        end
        ST_GRANT: begin
          if (bus.req[sel_q] && (cnt_q < CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (any) begin
            // The owner may re-win here only when nobody else is asking.
            sel_d  = idx;
            cnt_d  = '0;
            last_d = idx;
          end else begin
            // sel keeps pointing at the previous owner while idle.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: DMux8Way routing of grant_valid onto the line chosen by sel.
  always_comb begin
    bus.sel         = sel_q;
    bus.grant_valid = (state_q == ST_GRANT);
    bus.busy        = (state_q == ST_GRANT);
    bus.gnt         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.gnt[i] = bus.grant_valid && (sel_q == SEL_W'(i));
    end
  end

endmodule
